// File: rtl/led_blink_gen.sv
// Multi-channel LED / heartbeat generator: one shared prescaler feeding NCH
// independent counters, each driving an OFF, TOGGLE, PULSE or PWM output.
module led_blink_gen #(
  parameter int NCH   = 4,
  parameter int CW    = 25,
  parameter int PRESC = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clr,
  input  logic [2*NCH-1:0]  mode,
  input  logic [CW*NCH-1:0] period,
  input  logic [CW*NCH-1:0] duty,
  output logic [NCH-1:0]    led,
  output logic [NCH-1:0]    wrap
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_PWM    = 2'b11
  } mode_e;

  localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc;
  logic          tick;

  // With PRESC=1 the prescaler sits at zero and tick simply follows en.
  assign tick = en && (presc == PRESC_LAST);

  // NOTE: sequential state is written with non-blocking (<=) so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mode_e         ch_mode;
    mode_e         prev_mode;
    logic [CW-1:0] ch_period;
    logic [CW-1:0] ch_duty;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          led_q;
    logic          led_nxt;
    logic          wrap_q;
    logic          wrap_nxt;

    assign ch_mode   = mode_e'(mode[2*i +: 2]);
    assign ch_period = period[CW*i +: CW];
    assign ch_duty   = duty[CW*i +: CW];

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
      cnt_nxt  = cnt;
      led_nxt  = led_q;
      wrap_nxt = 1'b0;
      if (clr || (ch_mode != prev_mode) || (ch_mode == MODE_OFF)) begin
        cnt_nxt = '0;
        led_nxt = 1'b0;
      end else if (en) begin
        // >= rather than == so a period cut below the running count wraps at once.
        if (tick) begin
          if (cnt >= ch_period) begin
            cnt_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        unique case (ch_mode)
          MODE_TOGGLE: led_nxt = led_q ^ wrap_nxt;
          MODE_PULSE:  led_nxt = wrap_nxt;
          MODE_PWM:    led_nxt = (cnt_nxt < ch_duty);
          default:     led_nxt = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        cnt       <= '0;
        led_q     <= 1'b0;
        wrap_q    <= 1'b0;
        prev_mode <= MODE_OFF;
      end else begin
        cnt       <= cnt_nxt;
        led_q     <= led_nxt;
        wrap_q    <= wrap_nxt;
        prev_mode <= ch_mode;
      end
    end

    assign led[i]  = led_q;
    assign wrap[i] = wrap_q;
  end

endmodule

// File: tb/tb_led_blink_gen.sv
// Bench for led_blink_gen: a PRESC=2 and a PRESC=1 instance share stimulus and
// are compared every cycle against a rule-level model, plus directed scenarios.
module tb_led_blink_gen;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic              en;
  logic              clr;
  logic [2*NCH-1:0]  mode;
  logic [CW*NCH-1:0] period;
  logic [CW*NCH-1:0] duty;
  logic [NCH-1:0]    led0v, wrap0v, led1v, wrap1v;

  always #5 clk = ~clk;

  led_blink_gen #(.NCH(NCH), .CW(CW), .PRESC(2)) u_dut (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr), .mode(mode),
    .period(period), .duty(duty), .led(led0v), .wrap(wrap0v)
  );

  led_blink_gen #(.NCH(NCH), .CW(CW), .PRESC(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr), .mode(mode),
    .period(period), .duty(duty), .led(led1v), .wrap(wrap1v)
  );

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 mirrors the PRESC=2 instance, index 1 the PRESC=1 one.
  int       m_presc [2];
  int       m_cnt   [2][NCH];
  bit       m_led   [2][NCH];
  bit       m_wrap  [2][NCH];
  bit [1:0] m_prev  [2][NCH];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_presc[k] = 0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[k][i] = 0; m_led[k][i] = 0; m_wrap[k][i] = 0; m_prev[k][i] = 2'b00;
      end
    end
  endtask

  task automatic model_step(input int k, input int pdiv);
    bit       tk, w;
    int       p, d;
    bit [1:0] md;
    tk = en && (m_presc[k] == pdiv - 1);
    if (clr)     m_presc[k] = 0;
    else if (en) m_presc[k] = (m_presc[k] + 1) % pdiv;
    for (int i = 0; i < NCH; i++) begin
      md = mode[2*i +: 2];
      p  = int'(period[CW*i +: CW]);
      d  = int'(duty[CW*i +: CW]);
      if (clr || md != m_prev[k][i] || md == 2'b00) begin
        m_cnt[k][i] = 0; m_led[k][i] = 0; m_wrap[k][i] = 0;
      end else if (!en) begin
        m_wrap[k][i] = 0;
      end else begin
        w = tk && (m_cnt[k][i] >= p);
        if (tk) m_cnt[k][i] = w ? 0 : m_cnt[k][i] + 1;
        m_wrap[k][i] = w;
        case (md)
          2'b01:   m_led[k][i] = m_led[k][i] ^ w;
          2'b10:   m_led[k][i] = w;
          default: m_led[k][i] = (m_cnt[k][i] < d);
        endcase
      end
      m_prev[k][i] = md;
    end
  endtask

  function automatic logic [NCH-1:0] exp_vec(input int k, input bit want_led);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = want_led ? m_led[k][i] : m_wrap[k][i];
    return v;
  endfunction

  always @(negedge nrst) model_reset();

  always @(posedge clk) begin
    cyc++;
    if (!nrst) model_reset();
    else begin
      model_step(0, 2);
      model_step(1, 1);
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("model_led_p2",  led0v,  exp_vec(0, 1'b1));
      check("model_wrap_p2", wrap0v, exp_vec(0, 1'b0));
      check("model_led_p1",  led1v,  exp_vec(1, 1'b1));
      check("model_wrap_p1", wrap1v, exp_vec(1, 1'b0));
    end
  end

  task automatic wait_wrap(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrap0v[ch] && n < 1000);
    if (!wrap0v[ch]) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_wrap_ch%0d: no wrap within %0d cycles", ch, n);
    end
  endtask

  task automatic count_high(input int ch, input bit use_p1, input int len, output int hi);
    hi = 0;
    repeat (len) begin
      @(negedge clk);
      hi += use_p1 ? int'(led1v[ch]) : int'(led0v[ch]);
    end
  endtask

  typedef struct {
    logic           en;
    logic           clr;
    logic [NCH-1:0] exp_led;
    logic [NCH-1:0] exp_wrap;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int             n, hi, ref_cyc;
    logic           l1;
    logic [NCH-1:0] saved;

    // ch1 PULSE P=1, ch2 PWM P=1 D=1, PRESC=2, starting from a clear.
    tbl[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 1'b0, 4'b0100, 4'b0000};
    tbl[2]  = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b1, 1'b0, 4'b0110, 4'b0110};
    tbl[5]  = '{1'b1, 1'b0, 4'b0100, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 4'b0100, 4'b0000};
    tbl[7]  = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b1, 1'b0, 4'b0110, 4'b0110};
    tbl[10] = '{1'b1, 1'b0, 4'b0100, 4'b0000};
    tbl[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000};

    nrst = 1'b0; en = 1'b0; clr = 1'b0; mode = '0; period = '0; duty = '0;
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    check("reset_led",  led0v,  0);
    check("reset_wrap", wrap0v, 0);

    // Scenario 1: ch0 TOGGLE P=3.
    en = 1'b1; mode[1:0] = 2'b01; period[7:0] = 8'd3; nrst = 1'b1;
    wait_wrap(0, n);
    l1 = led0v[0];
    wait_wrap(0, n);
    check("s1_wrap0_gap", n, 8);
    check("s1_led0_toggle", led0v[0], !l1);

    // Scenario 2: ch1 PULSE P=0.
    mode[3:2] = 2'b10; period[15:8] = 8'd0;
    wait_wrap(1, n);
    wait_wrap(1, n);
    check("s2_wrap1_gap", n, 2);
    check("s2_led1_with_wrap1", led0v[1], 1);
    repeat (3) @(negedge clk);
    count_high(1, 1'b1, 10, hi);
    check("s2_presc1_led1_const", hi, 10);

    // Scenario 3: ch2 PWM P=9 with D=3, 0, 12.
    mode[5:4] = 2'b11; period[23:16] = 8'd9; duty[23:16] = 8'd3;
    repeat (4) @(negedge clk);
    count_high(2, 1'b0, 20, hi);
    check("s3_pwm_d3", hi, 6);
    duty[23:16] = 8'd0;
    repeat (2) @(negedge clk);
    count_high(2, 1'b0, 20, hi);
    check("s3_pwm_d0", hi, 0);
    duty[23:16] = 8'd12;
    repeat (2) @(negedge clk);
    count_high(2, 1'b0, 20, hi);
    check("s3_pwm_d12", hi, 20);

    // Scenario 4: ch0 P=200, cut to 10 at cnt=50.
    period[7:0] = 8'd200;
    wait_wrap(0, n);
    repeat (100) @(negedge clk);
    l1 = led0v[0];
    period[7:0] = 8'd10;
    wait_wrap(0, n);
    check("s4_wrap_after_cut", n, 2);
    check("s4_led0_toggle", led0v[0], !l1);
    wait_wrap(0, n);
    check("s4_wrap0_gap", n, 22);

    // Scenario 5: freeze, then clear while frozen, then restart.
    en = 1'b0;
    saved = led0v;
    repeat (10) begin
      @(negedge clk);
      check("s5_led_hold", led0v, saved);
      check("s5_wrap_zero", wrap0v, 0);
    end
    clr = 1'b1;
    @(negedge clk);
    check("s5_clr_led", led0v, 0);
    check("s5_clr_wrap", wrap0v, 0);
    clr = 1'b0; en = 1'b1;
    wait_wrap(0, n);
    check("s5_restart_first_wrap", n, 22);

    // Scenario 6: ch3 TOGGLE -> PWM mid-count; ch0 keeps its phase.
    mode = 8'b0100_0001; period[7:0] = 8'd3; period[31:24] = 8'd7;
    wait_wrap(0, n);
    wait_wrap(0, n);
    ref_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_wrap(3, n);
      if (led0v[3]) break;
    end
    check("s6_led3_high_before", led0v[3], 1);
    repeat (10) @(negedge clk);
    mode[7:6] = 2'b11; duty[31:24] = 8'd4;
    @(negedge clk);
    check("s6_led3_cleared", led0v[3], 0);
    @(negedge clk);
    check("s6_led3_pwm", led0v[3], 1);
    wait_wrap(0, n);
    check("s6_ch0_phase", (cyc - ref_cyc) % 8, 0);

    // Table-driven sequence.
    mode = 8'h38; period = 32'h0001_0100; duty = 32'h0001_0000; en = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 12; r++) begin
      en = tbl[r].en; clr = tbl[r].clr;
      @(negedge clk);
      check($sformatf("tbl_led_r%0d", r), led0v, tbl[r].exp_led);
      check($sformatf("tbl_wrap_r%0d", r), wrap0v, tbl[r].exp_wrap);
    end
    clr = 1'b0; en = 1'b1;

    // Randomized stimulus, checked cycle by cycle against the model.
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) mode[2*$urandom_range(0, NCH-1) +: 2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  period[CW*$urandom_range(0, NCH-1) +: CW] = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)  duty[CW*$urandom_range(0, NCH-1) +: CW] = CW'($urandom_range(0, 17));
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 49) == 0);
    end
    en = 1'b1; clr = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("async_rst_led_p2",  led0v,  0);
    check("async_rst_wrap_p2", wrap0v, 0);
    check("async_rst_led_p1",  led1v,  0);
    check("async_rst_wrap_p1", wrap1v, 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_blink_gen.md
Name: led_blink_gen

Overview:
- Multi-channel, parametrised successor to the single free-running LED counters used on the board bring-up top level.
- Each of NCH channels has its own programmable period and mode: off, toggle (square wave), one-cycle pulse, or PWM.
- A shared prescaler sets the count rate.
- Sits in the board top level on one clock domain, behind that domain's reset synchroniser; drives LEDs and heartbeat/strobe signals.

Parameters:
- NCH, 4, number of channels.
- CW, 25, width of per-channel counter, period and duty fields.
- PRESC, 1, shared prescaler divide ratio (>=1); one count tick every PRESC clk cycles.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; 0 freezes prescaler, counters and outputs
- clr  in  1  synchronous clear of prescaler, counters, outputs
- mode  in  2*NCH  per-channel mode, channel i at [2i+1:2i]: 00 OFF, 01 TOGGLE, 10 PULSE, 11 PWM
- period  in  CW*NCH  per-channel terminal count P, channel i at [CW*i+CW-1:CW*i]
- duty  in  CW*NCH  per-channel PWM high count D, same packing
- led  out  NCH  channel outputs, registered
- wrap  out  NCH  one-cycle strobe per counter wrap, registered

Behaviour:
- Reset (nrst=0, async): prescaler=0, all cnt=0, led=0, wrap=0, stored previous mode=00. All outputs are 0 from assertion, with no clock edge needed.
- Prescaler: counts 0..PRESC-1 while en=1.
  - tick = en && presc==PRESC-1 (combinational).
  - PRESC=1 gives tick=en.
- Priority per edge: clr > mode change > en/tick.
- clr=1: prescaler, all cnt, led, wrap <= 0, regardless of en.
- Mode change: if mode[i] differs from its stored previous value, then cnt[i]<=0, led[i]<=0, wrap[i]<=0, and the stored mode is updated. Other channels are unaffected.
- en=0: prescaler, cnt, led hold; wrap <= 0.
- Counter, channel i, mode != OFF, on tick:
  - if cnt[i] >= P[i]: cnt[i]<=0, wrap[i]<=1;
  - else cnt[i]<=cnt[i]+1, wrap[i]<=0.
  - The period is P+1 ticks. P=0 wraps on every tick.
  - Using >= means a period reduced below the current cnt wraps on the next tick; there is no run-out to 2^CW.
- Non-tick cycles: wrap[i]<=0.
- OFF mode: cnt[i] held at 0, led[i]=0, wrap[i]=0.
- TOGGLE: led[i] inverts on the same edge that wraps. Output period is 2*(P+1)*PRESC clk cycles.
- PULSE: led[i] <= same value as wrap[i]; high exactly one clk cycle per wrap.
- PWM: led[i] <= (next cnt[i] < D[i]), updated every edge, where next cnt is the value being loaded.
  - D=0 gives constant 0.
  - D>P gives constant 1 after the first edge.
- Latency: wrap/led rise on the edge where tick and cnt>=P; visible in the same cycle that cnt reads 0.
- Arithmetic: all compares are unsigned CW-bit. The counter never exceeds max(P, previous cnt), so there is no overflow.
- Reset mid-operation: async clear as above; the first tick after release occurs PRESC cycles after en is seen high.

Test Plan (NCH=4, CW=8, PRESC=2 unless stated):
1. nrst=0 asserted between edges → led=0, wrap=0 immediately. Release with en=1, ch0 mode=01, P=3 → wrap pulses every 8 clk; led0 toggles every 8 clk (period 16).
2. ch1 mode=10, P=0 → wrap1 and led1 high 1 clk every 2 clk. Same with PRESC=1 → led1 constantly high.
3. ch2 mode=11, P=9:
   - D=3 → led2 high 6 clk of every 20.
   - D=0 → stays 0.
   - D=12 → stays 1.
4. ch0 mode=01, P=200. At cnt=50 set P=10 → next tick cnt=0, wrap0=1, led0 toggles. Subsequent wraps every 22 clk.
5. en=0 mid-count → cnt, led held, wrap=0 for 10 clk. clr=1 with en=0 → next edge all cnt=0, led=0. en=1 → counting restarts from 0.
6. ch3 mode 01→11 while led3=1, cnt3=5 → next edge cnt3=0, led3=0, then PWM behaviour. Channels 0-2 are uninterrupted (compare wrap timing to the scenario 1 reference).
